// File: rtl/mat_vec_result_collector.sv
// Collects per-beat row_by_vector results into one committed vector.
// Optional sticky extra-beat flag: COLLECTOR_OVERFLOW_DETECT_EN.
module mat_vec_result_collector #(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width = 32,
  parameter int no_of_units = 4,
  parameter int NI = 8,
  localparam int additional =
    NI - (no_of_eqn_per_cluster % NI),
  localparam int total =
    no_of_eqn_per_cluster + additional,
  localparam int no_of_beats = total / no_of_units
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic outsider_read_now,
  input  logic [element_width*no_of_units-1:0] in_data,
  output logic [no_of_eqn_per_cluster*element_width-1:0] out_vector,
  output logic out_valid,
  output logic busy,
  output logic [$clog2(no_of_beats+1)-1:0] beat_count,
  output logic overflow
);

  localparam int N  = no_of_eqn_per_cluster;
  localparam int W  = element_width;
  localparam int U  = no_of_units;
  localparam int CW = $clog2(no_of_beats+1);
  localparam logic [CW-1:0] LAST = CW'(no_of_beats-1);

  typedef enum logic [1:0] {
    IDLE, COLLECT, COMMIT, DONE
  } state_t;

  state_t state;
  logic [N*W-1:0] assembly;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      assembly   <= '0;
      out_vector <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      beat_count <= '0;
    end else if (!start) begin
      state      <= IDLE;
      assembly   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      beat_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= COLLECT;
          busy  <= 1'b1;
        end
        COLLECT: begin
          if (outsider_read_now) begin
            // padded tail rows have no slot and are simply skipped
            for (int r = 0; r < N; r++) begin
              if (beat_count == CW'(r / U))
                assembly[(N-r)*W-1 -: W] <=
                  in_data[(U-(r%U))*W-1 -: W];
            end
            beat_count <= beat_count + 1'b1;
            if (beat_count == LAST)
              state <= COMMIT;
          end
        end
        COMMIT: begin
          out_vector <= assembly;
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= DONE;
        end
        DONE: begin
        end
      endcase
    end
  end

`ifdef COLLECTOR_OVERFLOW_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset || !start)
      overflow <= 1'b0;
    else if (outsider_read_now &&
             (state == COMMIT || state == DONE))
      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
